cpu_mem_responder: RTL and testbench
====================================

# cpu_mem_responder

Memory-side responder for the 5-stage pipelined RISC-V core's instruction and data ports. It holds separate instruction and data word memories and answers fetch and load/store requests with zero-cycle read latency. It also contains a byte-stream program loader FSM that fills instruction memory while holding the core in reset. Misaligned or out-of-range data accesses are flagged through a sticky fault with the first faulting address.

## Interface
- IMEM_WORDS, 1024: instruction memory depth in 32-bit words; power of two.
- DMEM_WORDS, 1024: data memory depth in 32-bit words; power of two.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- instr_addr  in  32  byte address of fetch, from core PC.
- instr_data  out  32  fetched word.
- data_addr  in  32  byte address of load/store.
- data_in  in  32  store data from core.
- data_out  out  32  load data to core.
- mem_we  in  1  store strobe.
- mem_re  in  1  load strobe.
- ld_valid  in  1  loader byte valid.
- ld_ready  out  1  loader byte accepted when valid&ready.
- ld_byte  in  8  program byte, little-endian word order.
- ld_last  in  1  marks final byte of program.
- cpu_rst  out  1  reset to core; high while not in RUN.
- fault  out  1  sticky data-access fault.
- fault_addr  out  32  data_addr of first fault.
- ld_words  out  16  count of words written by loader.

## Operation
- States: LOAD (after reset) and RUN. There is no return from RUN to LOAD except through rst.
- LOAD:
  - ld_ready=1.
  - Each accepted byte goes into lane byte_cnt (0..3) of an assembly register; byte 0 is bits [7:0].
  - When byte_cnt==3 is accepted, the word is written to imem[wptr]; wptr++, ld_words++, byte_cnt→0.
  - When ld_last is accepted with a partial word, the unfilled lanes are zero and the word is written.
  - Acceptance of ld_last → RUN.
  - Once wptr reaches IMEM_WORDS, further words are dropped, fault is set, and fault_addr is set to 0xFFFFFFFF if no earlier fault is recorded. Load continues until ld_last.
  - In LOAD: data ports are ignored, data_out=0, instr_data=NOP (0x00000013).
- RUN:
  - ld_ready=0.
  - instr_data = imem[instr_addr>>2] when instr_addr < 4*IMEM_WORDS, else NOP. Low two address bits are ignored.
  - Load: data_out = dmem[data_addr>>2] when mem_re=1 and the address is valid. Otherwise data_out=0. The core relies on a nonzero data_out only for real loads.
  - Store: when mem_we=1 and the address is valid, dmem[data_addr>>2] <= data_in at the rising edge.
  - A data address is valid when data_addr[1:0]==0 and data_addr < 4*DMEM_WORDS.
  - A strobe (we or re) to an invalid address sets fault sticky; fault_addr captures only the first fault. The store is suppressed.
  - mem_we and mem_re both high: the store executes and data_out returns the pre-edge (old) word.

## Timing
- Reset values:
  - state=LOAD, cpu_rst=1, ld_ready=1 (combinational from state).
  - fault=0, fault_addr=0, ld_words=0, byte_cnt=0, wptr=0.
  - data_out=0, instr_data=NOP.
  - Memory contents are not reset.
- Read latency is 0 cycles; instr_data and data_out are combinational from address, strobe, and state.
- Write latency: the value is visible on the read port the cycle after the store edge.
- Loader accepts 1 byte/cycle; there is no back-pressure in LOAD.
- The final-word write and LOAD→RUN occur on the same edge. cpu_rst is registered and falls on the following edge, so the core's first fetch sees the complete image.
- rst mid-LOAD or mid-RUN aborts immediately: state→LOAD, partial assembly discarded, imem contents retained.

## Structure
- Package cpu_mem_pkg holds:
  - NOP constant 0x00000013.
  - State encoding (LOAD, RUN).
  - Fault sentinel 0xFFFFFFFF.
  - Index-width helper (log2 of depth).
- Sub-module ld_word_assembler: byte_cnt, 32-bit shift/lane register, ld_last handling. It outputs word_valid and word.
- The top level holds the FSM, both memory arrays, address decode, and the fault register.

## Test plan
- Load bytes 13 05 A0 00 | 93 05 30 00 with ld_last on the 8th byte → imem[0]=0x00A00513, imem[1]=0x00300593, ld_words=2. cpu_rst falls 1 cycle after the ld_last edge.
- Load 5 bytes 01 02 03 04 AA with ld_last on AA → imem[1]=0x000000AA, ld_words=2.
- In RUN: store 0xDEADBEEF to 0x10, then load from 0x10 next cycle → data_out=0xDEADBEEF. With mem_re=0 → data_out=0.
- Store to 0x12 (misaligned) → dmem unchanged, fault=1, fault_addr=0x12. A later store to 4*DMEM_WORDS leaves fault_addr=0x12.
- Fetch from instr_addr=4*IMEM_WORDS → instr_data=0x00000013. Same-cycle we+re to 0x20 holding 5 with data_in 9 → data_out=5; the next-cycle read returns 9.
- Assert rst during the 3rd byte of a load → state=LOAD, cpu_rst=1, ld_words=0. A reload then writes from imem[0].

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared constants, state encoding and sizing helper for the CPU memory responder.
package cpu_mem_pkg;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;
    localparam logic [31:0] FAULT_SENTINEL = 32'hFFFF_FFFF;

    // Word-index width for a memory of the given depth (never below 1 bit).
    function automatic int unsigned idx_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ld_word_assembler.sv
// Packs a little-endian byte stream into 32-bit words; ld_last flushes a partial word zero-padded.
module ld_word_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    input  logic        last_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  byte_cnt_q;
    logic [31:0] lanes_q;

    // Lanes above byte_cnt_q are always zero, so OR-ing in the new byte yields the padded word.
    assign word_o       = lanes_q | (32'(byte_i) << {byte_cnt_q, 3'b000});
    assign word_valid_o = byte_valid_i && ((byte_cnt_q == 2'd3) || last_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt_q <= 2'd0;
            lanes_q    <= 32'd0;
        end else if (byte_valid_i) begin
            if (word_valid_o) begin
                byte_cnt_q <= 2'd0;
                lanes_q    <= 32'd0;
            end else begin
                byte_cnt_q <= byte_cnt_q + 2'd1;
                lanes_q    <= word_o;
            end
        end
    end

endmodule

// File: rtl/cpu_mem_responder.sv
// Instruction/data word memories for the pipelined core, with a byte-stream program loader
// that holds the core in reset until the image is complete.
module cpu_mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int unsigned IMEM_WORDS = 1024,
    parameter int unsigned DMEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_addr,
    output logic [31:0] instr_data,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    input  logic        mem_we,
    input  logic        mem_re,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [7:0]  ld_byte,
    input  logic        ld_last,
    output logic        cpu_rst,
    output logic        fault,
    output logic [31:0] fault_addr,
    output logic [15:0] ld_words
);

    localparam int unsigned IIW = idx_w(IMEM_WORDS);
    localparam int unsigned DIW = idx_w(DMEM_WORDS);

    logic [31:0] imem [IMEM_WORDS];
    logic [31:0] dmem [DMEM_WORDS];

    state_e      state_q;
    logic        cpu_rst_q;
    logic        fault_q;
    logic [31:0] fault_addr_q;
    logic [15:0] ld_words_q;
    logic [IIW:0] wptr_q;

    logic         in_load_c;
    logic         in_run_c;
    logic         word_valid_c;
    logic [31:0]  word_c;
    logic         imem_we_c;
    logic         dmem_we_c;
    logic         d_valid_c;
    logic         i_hit_c;
    logic [DIW-1:0] d_idx_c;
    logic [IIW-1:0] i_idx_c;
    logic         unused_c;

    assign in_load_c = (state_q == ST_LOAD);
    assign in_run_c  = (state_q == ST_RUN);

    ld_word_assembler u_asm (
        .clk          (clk),
        .rst          (rst),
        .byte_valid_i (ld_valid && in_load_c),
        .byte_i       (ld_byte),
        .last_i       (ld_last),
        .word_valid_o (word_valid_c),
        .word_o       (word_c)
    );

    // Address decode: word index plus range/alignment qualification.
    assign d_valid_c = (data_addr[1:0] == 2'b00) && (data_addr[31:DIW+2] == '0);
    assign d_idx_c   = data_addr[DIW+1:2];
    assign i_hit_c   = (instr_addr[31:IIW+2] == '0);
    assign i_idx_c   = instr_addr[IIW+1:2];
    assign unused_c  = ^instr_addr[1:0];

    // wptr_q MSB set means the image has filled instruction memory.
    assign imem_we_c = in_load_c && word_valid_c && !wptr_q[IIW];
    assign dmem_we_c = in_run_c && mem_we && d_valid_c;

    assign instr_data = (in_run_c && i_hit_c) ? imem[i_idx_c] : NOP_INSTR;
    assign data_out   = (in_run_c && mem_re && d_valid_c) ? dmem[d_idx_c] : 32'd0;
    assign ld_ready   = in_load_c;
    assign cpu_rst    = cpu_rst_q;
    assign fault      = fault_q;
    assign fault_addr = fault_addr_q;
    assign ld_words   = ld_words_q;

    always_ff @(posedge clk) begin
        if (imem_we_c) begin
            imem[wptr_q[IIW-1:0]] <= word_c;
        end
    end

    always_ff @(posedge clk) begin
        if (dmem_we_c) begin
            dmem[d_idx_c] <= data_in;
        end
    end

    // Loader/run FSM with the sticky fault record; cpu_rst trails the state by one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_LOAD;
            cpu_rst_q    <= 1'b1;
            fault_q      <= 1'b0;
            fault_addr_q <= 32'd0;
            ld_words_q   <= 16'd0;
            wptr_q       <= '0;
        end else begin
            cpu_rst_q <= !in_run_c;
            case (state_q)
                ST_LOAD: begin
                    if (word_valid_c) begin
                        if (!wptr_q[IIW]) begin
                            wptr_q     <= wptr_q + (IIW+1)'(1);
                            ld_words_q <= ld_words_q + 16'd1;
                        end else begin
                            fault_q <= 1'b1;
                            if (!fault_q) begin
                                fault_addr_q <= FAULT_SENTINEL;
                            end
                        end
                    end
                    if (ld_valid && ld_last) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if ((mem_we || mem_re) && !d_valid_c) begin
                        fault_q <= 1'b1;
                        if (!fault_q) begin
                            fault_addr_q <= data_addr;
                        end
                    end
                end
                default: state_q <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed and randomized checks of the memory responder against a word-level reference model.
module tb_cpu_mem_responder;

    localparam int unsigned IMW = 64;
    localparam int unsigned DMW = 64;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_addr, instr_data, data_addr, data_in, data_out;
    logic        mem_we, mem_re, ld_valid, ld_ready, ld_last, cpu_rst, fault;
    logic [7:0]  ld_byte;
    logic [31:0] fault_addr;
    logic [15:0] ld_words;

    int checks = 0;
    int errors = 0;

    logic [31:0] imem_m [IMW];
    logic [31:0] dmem_m [DMW];
    bit          dwr_m  [DMW];
    bit          fault_m;
    logic [31:0] fault_addr_m;
    int          ld_words_m;

    always #5 clk = ~clk;

    cpu_mem_responder #(.IMEM_WORDS(IMW), .DMEM_WORDS(DMW)) dut (
        .clk        (clk),
        .rst        (rst),
        .instr_addr (instr_addr),
        .instr_data (instr_data),
        .data_addr  (data_addr),
        .data_in    (data_in),
        .data_out   (data_out),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_byte    (ld_byte),
        .ld_last    (ld_last),
        .cpu_rst    (cpu_rst),
        .fault      (fault),
        .fault_addr (fault_addr),
        .ld_words   (ld_words)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        ld_valid = 1'b0; ld_last = 1'b0; ld_byte = 8'h00;
        mem_we = 1'b0; mem_re = 1'b0; data_addr = 32'd0; data_in = 32'd0;
        instr_addr = 32'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        @(posedge clk); #1;
        rst = 1'b0;
        fault_m = 1'b0; fault_addr_m = 32'd0; ld_words_m = 0;
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_fault"}, 32'(fault), 32'(fault_m));
        chk({tag, "_fault_addr"}, fault_addr, fault_addr_m);
    endtask

    // Streams a program image, then verifies the expected word count and reset release.
    task automatic load_prog(input logic [7:0] q[$]);
        int n = q.size();
        int nw = (n + 3) / 4;
        for (int i = 0; i < n; i++) begin
            ld_valid = 1'b1; ld_byte = q[i]; ld_last = (i == n - 1);
            data_addr = $urandom; data_in = $urandom; mem_we = 1'($urandom); mem_re = 1'b1;
            instr_addr = 32'($urandom_range(0, 255));
            #1;
            if (i % 8 == 0) begin
                chk("load_ready", 32'(ld_ready), 32'd1);
                chk("load_instr_nop", instr_data, NOP);
                chk("load_data_zero", data_out, 32'd0);
            end
            @(posedge clk); #1;
        end
        idle();
        for (int w = 0; w < nw; w++) begin
            logic [31:0] word = 32'd0;
            for (int b = 0; b < 4; b++)
                if (w * 4 + b < n) word[b*8 +: 8] = q[w*4 + b];
            if (w < int'(IMW)) imem_m[w] = word;
            else begin
                if (!fault_m) fault_addr_m = 32'hFFFF_FFFF;
                fault_m = 1'b1;
            end
        end
        ld_words_m = (nw < int'(IMW)) ? nw : int'(IMW);
        #1;
        chk("run_ready_low", 32'(ld_ready), 32'd0);
        chk("cpu_rst_hold", 32'(cpu_rst), 32'd1);
        @(posedge clk); #1;
        chk("cpu_rst_release", 32'(cpu_rst), 32'd0);
        chk("ld_words", 32'(ld_words), 32'(ld_words_m));
        check_status("after_load");
    endtask

    task automatic check_imem(input int nw);
        for (int w = 0; w < nw && w < int'(IMW); w++) begin
            instr_addr = 32'(w * 4) + 32'($urandom_range(0, 3));
            #1;
            chk($sformatf("fetch_%0d", w), instr_data, imem_m[w]);
        end
        instr_addr = 32'd0;
    endtask

    // One data-port cycle: check the combinational read, take the edge, update the model.
    task automatic data_op(input logic we, input logic re, input logic [31:0] addr, input logic [31:0] din);
        bit valid = (addr[1:0] == 2'b00) && (addr < 32'(4 * DMW));
        int idx = int'(addr >> 2);
        mem_we = we; mem_re = re; data_addr = addr; data_in = din;
        #1;
        if (re && valid) begin
            if (dwr_m[idx]) chk($sformatf("load_0x%0h", addr), data_out, dmem_m[idx]);
        end else begin
            chk($sformatf("data_zero_0x%0h", addr), data_out, 32'd0);
        end
        @(posedge clk); #1;
        if (we && valid) begin
            dmem_m[idx] = din;
            dwr_m[idx]  = 1'b1;
        end
        if ((we || re) && !valid) begin
            if (!fault_m) fault_addr_m = addr;
            fault_m = 1'b1;
        end
        mem_we = 1'b0; mem_re = 1'b0;
    endtask

    initial begin
        logic [7:0] q[$];
        for (int i = 0; i < int'(DMW); i++) dwr_m[i] = 1'b0;
        rst = 1'b1;
        idle();
        #3;
        chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rst_ld_ready", 32'(ld_ready), 32'd1);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_fault_addr", fault_addr, 32'd0);
        chk("rst_ld_words", 32'(ld_words), 32'd0);
        chk("rst_data_out", data_out, 32'd0);
        chk("rst_instr_nop", instr_data, NOP);
        do_reset();

        q = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h30, 8'h00};
        load_prog(q);
        check_imem(2);
        chk("imem0_literal", imem_m[0], 32'h00A0_0513);

        data_op(1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF);
        data_op(1'b0, 1'b1, 32'h10, 32'd0);
        data_op(1'b0, 1'b0, 32'h10, 32'd0);
        for (int i = 0; i < 60; i++)
            data_op(1'($urandom), 1'($urandom), 32'($urandom_range(0, DMW - 1) * 4), $urandom);
        check_status("random_data");

        data_op(1'b1, 1'b0, 32'h12, 32'h1234_5678);
        check_status("misaligned");
        data_op(1'b0, 1'b1, 32'h10, 32'd0);
        data_op(1'b1, 1'b0, 32'(4 * DMW), 32'h5555_AAAA);
        check_status("second_fault");

        instr_addr = 32'(4 * IMW);
        #1;
        chk("fetch_oob_nop", instr_data, NOP);
        data_op(1'b1, 1'b0, 32'h20, 32'd5);
        data_op(1'b1, 1'b1, 32'h20, 32'd9);
        data_op(1'b0, 1'b1, 32'h20, 32'd0);
        chk("model_wr_read", dmem_m[8], 32'd9);

        do_reset();
        check_status("reset_clears_fault");
        for (int i = 0; i < 6; i++) begin
            ld_valid = 1'b1; ld_byte = 8'(8'h11 * (i + 1));
            @(posedge clk); #1;
        end
        chk("partial_ld_words", 32'(ld_words), 32'd1);
        ld_valid = 1'b1; ld_byte = 8'h77;
        #2 rst = 1'b1;
        #1;
        chk("abort_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("abort_ld_words", 32'(ld_words), 32'd0);
        chk("abort_ld_ready", 32'(ld_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        idle();
        q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hAA};
        load_prog(q);
        check_imem(2);
        chk("partial_word_literal", imem_m[1], 32'h0000_00AA);

        for (int r = 0; r < 2; r++) begin
            int n = $urandom_range(1, 23);
            do_reset();
            q.delete();
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            load_prog(q);
            check_imem((n + 3) / 4);
        end

        do_reset();
        q.delete();
        for (int i = 0; i < int'(IMW) * 4 + 5; i++) q.push_back(8'($urandom));
        load_prog(q);
        check_imem(int'(IMW));
        chk("overflow_fault", 32'(fault), 32'd1);
        chk("overflow_sentinel", fault_addr, 32'hFFFF_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
